// File: rtl/write_dest_pipe.sv
// rtl/write_dest_pipe.sv - destination-register select and writeback pipe with RAW hazard detect
module write_dest_pipe #(
    parameter int REG_AW   = 5,
    parameter int STAGES   = 3,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        RegDst,
    input  logic              RegWrite,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rs_q,
    input  logic [REG_AW-1:0] rt_q,
    output logic [REG_AW-1:0] dest_sel,
    output logic [REG_AW-1:0] WriteReg,
    output logic              wb_en,
    output logic              hazard_rs,
    output logic              hazard_rt,
    output logic [CNT_W-1:0]  pend_cnt
);

    logic [STAGES-1:0] r_valid;
    logic [REG_AW-1:0] r_addr [STAGES];
    logic [CNT_W-1:0]  r_pend;

    logic [REG_AW-1:0] w_dest_sel;
    logic              w_load_valid;
    logic [STAGES-1:0] w_valid_nxt;
    logic [CNT_W-1:0]  w_pend_nxt;
    logic              w_hit_rs;
    logic              w_hit_rt;

    always_comb begin
        w_dest_sel = '0;
        case (RegDst)
            2'd0:    w_dest_sel = rt;
            2'd1:    w_dest_sel = rd;
            2'd2:    w_dest_sel = REG_AW'(LINK_REG);
            default: w_dest_sel = '0;
        endcase
    end

    // $0 and RegDst=3 never produce an entry; flush discards a same-cycle issue
    assign w_load_valid = issue & ~stall & ~flush & RegWrite
                        & (RegDst != 2'd3) & (w_dest_sel != '0);

    always_comb begin
        w_valid_nxt    = '0;
        w_valid_nxt[0] = w_load_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_valid_nxt[k] = r_valid[k-1] & ~flush;
        end
        w_pend_nxt = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_pend_nxt = w_pend_nxt + CNT_W'(w_valid_nxt[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_pend  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_addr[k] <= '0;
            end
        end else begin
            r_valid   <= w_valid_nxt;
            r_pend    <= w_pend_nxt;
            r_addr[0] <= w_dest_sel;
            for (int k = 1; k < STAGES; k++) begin
                r_addr[k] <= r_addr[k-1];
            end
        end
    end

    // Writeback stage is included: the register file does not forward same-cycle writes
    always_comb begin
        w_hit_rs = 1'b0;
        w_hit_rt = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (r_valid[k] && (r_addr[k] == rs_q)) w_hit_rs = 1'b1;
            if (r_valid[k] && (r_addr[k] == rt_q)) w_hit_rt = 1'b1;
        end
    end

    assign dest_sel  = w_dest_sel;
    assign WriteReg  = r_addr[STAGES-1];
    assign wb_en     = r_valid[STAGES-1];
    assign pend_cnt  = r_pend;
    assign hazard_rs = w_hit_rs & (rs_q != '0);
    assign hazard_rt = w_hit_rt & (rt_q != '0);

endmodule
